// File: rtl/attitude_hysteresis_encoder_if.sv
// Sample/result bundle between the IMU sample path and the attitude encoder.
// The master drives samples and reads codes; the slave is the encoder itself.
interface attitude_hysteresis_encoder_if #(
    parameter int DATA_W = 16
);
    logic              i_Valid;
    logic [DATA_W-1:0] i_Roll_Raw;
    logic [DATA_W-1:0] i_Pitch_Raw;
    logic              o_Valid;
    logic [3:0]        o_Attitude;
    logic              o_Changed;

    modport master (
        output i_Valid, i_Roll_Raw, i_Pitch_Raw,
        input  o_Valid, o_Attitude, o_Changed
    );

    modport slave (
        input  i_Valid, i_Roll_Raw, i_Pitch_Raw,
        output o_Valid, o_Attitude, o_Changed
    );
endinterface

// File: rtl/attitude_hysteresis_encoder.sv
// Roll/pitch to 4-bit attitude code with hysteresis and per-axis debounce.
// Pipeline: threshold classify -> per-axis LEVEL/TILT FSM -> registered code.
module attitude_hysteresis_encoder #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 4,
    parameter int THRESH_HI = 10,
    parameter int THRESH_LO = 8,
    parameter int DEBOUNCE  = 3
) (
    input logic                          i_Clk,
    input logic                          i_Rst_n,
    attitude_hysteresis_encoder_if.slave bus
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic {LEVEL = 1'b0, TILT = 1'b1} axis_state_t;

    logic              s1_valid_reg;
    logic              s2_valid_reg;
    logic [1:0]        tilt;
    logic [1:0]        sgn_out;
    logic [3:0]        attitude_next;
    logic [DATA_W-1:0] raw [2];

    // Axis 1 is roll, axis 0 is pitch, matching the bit order of the code.
    assign raw[0] = bus.i_Pitch_Raw;
    assign raw[1] = bus.i_Roll_Raw;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic [DATA_W-1:0] mag;
            logic [DATA_W-1:0] deg;
            logic              sign_reg, hi_reg, lo_reg, sign_s2_reg;
            axis_state_t       state_reg, state_next;
            logic [CW-1:0]     cnt_reg, cnt_next;
            logic              tilt_axis, sgn_axis;

            // Most-negative input saturates so it still reads as a large tilt.
            always_comb begin
                mag = raw[gi];
                if (raw[gi][DATA_W-1]) begin
                    if (raw[gi] == {1'b1, {(DATA_W-1){1'b0}}})
                        mag = {1'b0, {(DATA_W-1){1'b1}}};
                    else
                        mag = ~raw[gi] + 1'b1;
                end
            end

            assign deg = mag >> FRAC_BITS;

            always_ff @(posedge i_Clk or negedge i_Rst_n) begin
                if (!i_Rst_n) begin
                    sign_reg <= 1'b0;
                    hi_reg   <= 1'b0;
                    lo_reg   <= 1'b0;
                end else if (bus.i_Valid) begin
                    sign_reg <= raw[gi][DATA_W-1];
                    hi_reg   <= deg > DATA_W'(THRESH_HI);
                    lo_reg   <= deg < DATA_W'(THRESH_LO);
                end
            end

            always_ff @(posedge i_Clk or negedge i_Rst_n) begin
                if (!i_Rst_n) begin
                    state_reg   <= LEVEL;
                    cnt_reg     <= '0;
                    sign_s2_reg <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    if (s1_valid_reg)
                        sign_s2_reg <= sign_reg;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                if (s1_valid_reg) begin
                    if (!((state_reg == TILT) ? lo_reg : hi_reg)) begin
                        cnt_next = '0;
                    end else if (cnt_reg == CW'(DEBOUNCE - 1)) begin
                        state_next = (state_reg == TILT) ? LEVEL : TILT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            // Sign is suppressed while level so it cannot flicker around zero.
            always_comb begin
                tilt_axis = (state_reg == TILT);
                sgn_axis  = tilt_axis & sign_s2_reg;
            end

            assign tilt[gi]    = tilt_axis;
            assign sgn_out[gi] = sgn_axis;
        end
    endgenerate

    assign attitude_next = {sgn_out[1], sgn_out[0], tilt[1], tilt[0]};

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            s1_valid_reg   <= 1'b0;
            s2_valid_reg   <= 1'b0;
            bus.o_Valid    <= 1'b0;
            bus.o_Attitude <= 4'b0000;
            bus.o_Changed  <= 1'b0;
        end else begin
            s1_valid_reg <= bus.i_Valid;
            s2_valid_reg <= s1_valid_reg;
            bus.o_Valid  <= s2_valid_reg;
            if (s2_valid_reg) begin
                bus.o_Attitude <= attitude_next;
                bus.o_Changed  <= (attitude_next != bus.o_Attitude);
            end else begin
                bus.o_Changed  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_attitude_hysteresis_encoder.sv
// Directed bench for attitude_hysteresis_encoder: vector table plus
// hand-written gap, back-to-back and mid-stream reset sequences.
module tb_attitude_hysteresis_encoder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    attitude_hysteresis_encoder_if #(.DATA_W(16)) bus ();

    attitude_hysteresis_encoder #(
        .DATA_W(16), .FRAC_BITS(4), .THRESH_HI(10), .THRESH_LO(8), .DEBOUNCE(3)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] roll;
        logic [15:0] pitch;
        logic [3:0]  att;
        logic        ch;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One sample, then wait (bounded) for its result pulse.
    task automatic send(input logic [15:0] r, input logic [15:0] p,
                        output logic [3:0] att, output logic ch, output int lat);
        bus.i_Roll_Raw  = r;
        bus.i_Pitch_Raw = p;
        bus.i_Valid     = 1'b1;
        @(negedge clk);
        bus.i_Valid = 1'b0;
        lat = 0;
        while (!bus.o_Valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        att = bus.o_Attitude;
        ch  = bus.o_Changed;
        $display("txn roll=%h pitch=%h att=%b changed=%b latency=%0d", r, p, att, ch, lat);
    endtask

    task automatic push(input logic [15:0] r, input logic [15:0] p,
                        input logic [3:0] a, input logic c);
        vec_t v;
        v.roll = r; v.pitch = p; v.att = a; v.ch = c;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] att;
        logic       ch;
        int         lat;
        logic       gap_valid;
        logic       ov  [6];
        logic [3:0] oa  [6];
        logic       oc  [6];

        // Threshold crossing and debounce on roll.
        push(16'h00C0, 16'h0000, 4'b0000, 1'b0);
        push(16'h00C0, 16'h0000, 4'b0000, 1'b0);
        push(16'h00C0, 16'h0000, 4'b0010, 1'b1);
        for (int i = 0; i < 5; i++) push(16'h0090, 16'h0000, 4'b0010, 1'b0);
        push(16'h0070, 16'h0000, 4'b0010, 1'b0);
        push(16'h0070, 16'h0000, 4'b0010, 1'b0);
        push(16'h0070, 16'h0000, 4'b0000, 1'b1);
        // Simultaneous tilt of both axes, negative roll.
        push(16'hFF40, 16'h0140, 4'b0000, 1'b0);
        push(16'hFF40, 16'h0140, 4'b0000, 1'b0);
        push(16'hFF40, 16'h0140, 4'b1011, 1'b1);
        for (int i = 0; i < 3; i++) push(16'h8000, 16'h0140, 4'b1011, 1'b0);
        // Alternating 5/12 degrees never completes a debounce run.
        push(16'h0050, 16'h0140, 4'b0011, 1'b1);
        for (int i = 1; i < 10; i++)
            push((i % 2) ? 16'h00C0 : 16'h0050, 16'h0140, 4'b0011, 1'b0);
        push(16'h0050, 16'h0140, 4'b0011, 1'b0);
        push(16'h0050, 16'h0140, 4'b0011, 1'b0);
        push(16'h0050, 16'h0140, 4'b0001, 1'b1);
        // Sign forced to 0 while level; negative pitch sign while tilted.
        push(16'hFFB0, 16'h0140, 4'b0001, 1'b0);
        push(16'h0000, 16'hFEC0, 4'b0101, 1'b1);
        // Exactly 10 degrees does not request; it also clears the count.
        push(16'h00AF, 16'hFEC0, 4'b0101, 1'b0);
        push(16'h00B0, 16'hFEC0, 4'b0101, 1'b0);
        push(16'h00B0, 16'hFEC0, 4'b0101, 1'b0);
        push(16'h00A0, 16'hFEC0, 4'b0101, 1'b0);

        bus.i_Valid     = 1'b0;
        bus.i_Roll_Raw  = 16'h0000;
        bus.i_Pitch_Raw = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset_valid",   {31'd0, bus.o_Valid},   32'd0);
        check("reset_att",     {28'd0, bus.o_Attitude}, 32'd0);
        check("reset_changed", {31'd0, bus.o_Changed}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            send(vecs[i].roll, vecs[i].pitch, att, ch, lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd2);
            check($sformatf("vec%0d_att", i), {28'd0, att}, {28'd0, vecs[i].att});
            check($sformatf("vec%0d_changed", i), {31'd0, ch}, {31'd0, vecs[i].ch});
        end

        // Idle gaps between samples must not reset the debounce count.
        for (int k = 0; k < 3; k++) begin
            send(16'h00C0, 16'hFEC0, att, ch, lat);
            check($sformatf("gap%0d_att", k), {28'd0, att}, (k == 2) ? 32'h7 : 32'h5);
            check($sformatf("gap%0d_changed", k), {31'd0, ch}, (k == 2) ? 32'd1 : 32'd0);
            gap_valid = 1'b0;
            repeat (5) begin
                @(negedge clk);
                gap_valid = gap_valid | bus.o_Valid;
            end
            check($sformatf("gap%0d_idle_valid", k), {31'd0, gap_valid}, 32'd0);
            check($sformatf("gap%0d_hold_att", k), {28'd0, bus.o_Attitude},
                  (k == 2) ? 32'h7 : 32'h5);
        end

        // Back-to-back samples yield back-to-back result pulses.
        for (int c = 0; c < 6; c++) begin
            bus.i_Valid     = (c < 3);
            bus.i_Roll_Raw  = 16'h0070;
            bus.i_Pitch_Raw = 16'hFEC0;
            @(negedge clk);
            ov[c] = bus.o_Valid;
            oa[c] = bus.o_Attitude;
            oc[c] = bus.o_Changed;
        end
        for (int c = 0; c < 6; c++) begin
            $display("txn b2b cycle=%0d valid=%b att=%b changed=%b", c, ov[c], oa[c], oc[c]);
            check($sformatf("b2b%0d_valid", c), {31'd0, ov[c]}, (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
        end
        check("b2b0_att", {28'd0, oa[2]}, 32'h7);
        check("b2b1_att", {28'd0, oa[3]}, 32'h7);
        check("b2b2_att", {28'd0, oa[4]}, 32'h5);
        check("b2b0_changed", {31'd0, oc[2]}, 32'd0);
        check("b2b2_changed", {31'd0, oc[4]}, 32'd1);

        // Reset asserted mid-stream clears outputs without waiting for a clock.
        for (int c = 0; c < 3; c++) begin
            bus.i_Valid     = 1'b1;
            bus.i_Roll_Raw  = 16'h00C0;
            bus.i_Pitch_Raw = 16'h0000;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        $display("txn midreset valid=%b att=%b changed=%b", bus.o_Valid, bus.o_Attitude, bus.o_Changed);
        check("midrst_valid",   {31'd0, bus.o_Valid},    32'd0);
        check("midrst_att",     {28'd0, bus.o_Attitude}, 32'd0);
        check("midrst_changed", {31'd0, bus.o_Changed},  32'd0);
        bus.i_Valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gap_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            gap_valid = gap_valid | bus.o_Valid;
        end
        check("postrst_no_stale_valid", {31'd0, gap_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            send(16'h00C0, 16'h0000, att, ch, lat);
            check($sformatf("postrst%0d_latency", k), lat, 32'd2);
            check($sformatf("postrst%0d_att", k), {28'd0, att}, (k == 2) ? 32'h2 : 32'h0);
            check($sformatf("postrst%0d_changed", k), {31'd0, ch}, (k == 2) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
